// File: rtl/ingress_tlp_classify_pkg.sv
// Shared types for the ingress TLP classifier: header record, class enum,
// TLP type codes and the first-beat header decoder.
package ingress_tlp_classify_pkg;

  localparam int unsigned PCIE_DATA_WIDTH = 128;
  localparam int unsigned PCIE_DATA_KW    = 4;
  localparam int unsigned HDR_W           = 128;

  localparam logic [4:0] TLP_TYPE_MEM   = 5'b00000;
  localparam logic [4:0] TLP_TYPE_MEMLK = 5'b00001;
  localparam logic [4:0] TLP_TYPE_IO    = 5'b00010;
  localparam logic [4:0] TLP_TYPE_CFG0  = 5'b00100;
  localparam logic [4:0] TLP_TYPE_CFG1  = 5'b00101;
  localparam logic [4:0] TLP_TYPE_CPL   = 5'b01010;
  localparam logic [4:0] TLP_TYPE_CPLLK = 5'b01011;

  typedef enum logic [1:0] {
    CLS_CPL  = 2'd0,
    CLS_REQ  = 2'd1,
    CLS_DROP = 2'd2
  } tlp_class_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        td;
    logic        ep;
    logic [10:0] length;
    logic        hdr4dw;
    logic [15:0] req_id;
    logic [15:0] cpl_id;
    logic [7:0]  tag;
    logic [2:0]  status;
    logic [11:0] byte_cnt;
    logic [6:0]  low_addr;
    logic [7:0]  be;
    logic [63:0] addr;
  } tlp_head_t;

  function automatic tlp_class_e classify_type(input logic [4:0] t);
    if (t == TLP_TYPE_CPL) return CLS_CPL;
    if (t == TLP_TYPE_MEM || t == TLP_TYPE_MEMLK || t == TLP_TYPE_IO ||
        t == TLP_TYPE_CFG0 || t == TLP_TYPE_CFG1) return CLS_REQ;
    return CLS_DROP;
  endfunction

  // Completion and request headers share DW1/DW2 with different layouts.
  function automatic tlp_head_t decode_hdr(input logic [HDR_W-1:0] hdr);
    tlp_head_t   h;
    logic [31:0] dw0, dw1, dw2, dw3;
    dw0 = hdr[31:0];
    dw1 = hdr[63:32];
    dw2 = hdr[95:64];
    dw3 = hdr[127:96];
    h          = '0;
    h.fmt      = dw0[31:29];
    h.tlp_type = dw0[28:24];
    h.td       = dw0[15];
    h.ep       = dw0[14];
    h.length   = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
    h.hdr4dw   = dw0[29];
    if (dw0[28:24] == TLP_TYPE_CPL || dw0[28:24] == TLP_TYPE_CPLLK) begin
      h.cpl_id   = dw1[31:16];
      h.status   = dw1[15:13];
      h.byte_cnt = dw1[11:0];
      h.req_id   = dw2[31:16];
      h.tag      = dw2[15:8];
      h.low_addr = dw2[6:0];
    end else begin
      h.req_id = dw1[31:16];
      h.tag    = dw1[15:8];
      h.be     = dw1[7:0];
      h.addr   = dw0[29] ? {dw2, dw3} : {32'd0, dw2};
    end
    return h;
  endfunction

endpackage

// File: rtl/ingress_out_slot.sv
// One-entry output register with valid/ready; holds its contents while stalled.
module ingress_out_slot
  import ingress_tlp_classify_pkg::*;
#(
  parameter int unsigned DATA_W = PCIE_DATA_WIDTH,
  parameter int unsigned KW     = PCIE_DATA_KW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KW-1:0]     in_keep,
  input  logic              in_sop,
  input  logic              in_eop,
  input  tlp_head_t         in_meta,
  output logic              free_c,
  output logic [DATA_W-1:0] out_data,
  output logic [KW-1:0]     out_keep,
  output logic              out_sop,
  output logic              out_eop,
  output tlp_head_t         out_meta,
  output logic              out_valid,
  input  logic              out_rdy
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KW-1:0]     keep_q, keep_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  tlp_head_t         meta_q, meta_d;

  assign free_c = !valid_q || out_rdy;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    meta_d  = meta_q;
    if (out_rdy) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      keep_d  = in_keep;
      sop_d   = in_sop;
      eop_d   = in_eop;
      meta_d  = in_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      meta_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      meta_q  <= meta_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_meta  = meta_q;

endmodule

// File: rtl/ingress_tlp_classify.sv
// Ingress TLP classifier: decodes the first beat, steers completions and
// requests to their output slots, and discards/counts everything else.
module ingress_tlp_classify
  import ingress_tlp_classify_pkg::*;
#(
  parameter int unsigned DATA_W  = PCIE_DATA_WIDTH,
  parameter int unsigned KW      = PCIE_DATA_KW,
  parameter int unsigned DROP_CW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_axis_rx_tdata,
  input  logic [KW-1:0]      s_axis_rx_tkeep,
  input  logic               s_axis_rx_tlast,
  input  logic               s_axis_rx_tvalid,
  output logic               s_axis_rx_tready,
  output logic [DATA_W-1:0]  cpl_data,
  output logic [KW-1:0]      cpl_keep,
  output logic               cpl_sop,
  output logic               cpl_eop,
  output tlp_head_t          cpl_meta,
  output logic               cpl_valid,
  input  logic               cpl_rdy,
  output logic [DATA_W-1:0]  req_data,
  output logic [KW-1:0]      req_keep,
  output logic               req_sop,
  output logic               req_eop,
  output tlp_head_t          req_meta,
  output logic               req_valid,
  input  logic               req_rdy,
  output logic [DROP_CW-1:0] drop_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_CPL, ST_REQ, ST_DROP} state_e;

  state_e             state_q, state_d;
  tlp_head_t          meta_q, meta_d;
  logic [DROP_CW-1:0] drop_q, drop_d;
  tlp_head_t          hdr_c;
  tlp_class_e         cls_c;
  logic               cpl_free_c, req_free_c;
  logic               tready_c, accept_c, first_c;
  logic               cpl_load_c, req_load_c;

  assign hdr_c   = decode_hdr(HDR_W'(s_axis_rx_tdata));
  assign cls_c   = classify_type(hdr_c.tlp_type);
  assign first_c = (state_q == ST_IDLE);

  // A new TLP waits for both slots to be empty or draining, which keeps order.
  always_comb begin
    tready_c = 1'b0;
    case (state_q)
      ST_IDLE: tready_c = cpl_free_c && req_free_c;
      ST_CPL:  tready_c = cpl_free_c;
      ST_REQ:  tready_c = req_free_c;
      ST_DROP: tready_c = 1'b1;
      default: tready_c = 1'b0;
    endcase
    if (rst) tready_c = 1'b0;
  end

  assign accept_c = s_axis_rx_tvalid && tready_c;

  always_comb begin
    state_d    = state_q;
    meta_d     = meta_q;
    drop_d     = drop_q;
    cpl_load_c = 1'b0;
    req_load_c = 1'b0;
    if (accept_c) begin
      if (first_c) begin
        meta_d = hdr_c;
        case (cls_c)
          CLS_CPL: begin
            state_d    = ST_CPL;
            cpl_load_c = 1'b1;
          end
          CLS_REQ: begin
            state_d    = ST_REQ;
            req_load_c = 1'b1;
          end
          default: begin
            state_d = ST_DROP;
            if (drop_q != '1) drop_d = drop_q + DROP_CW'(1);
          end
        endcase
      end else begin
        cpl_load_c = (state_q == ST_CPL);
        req_load_c = (state_q == ST_REQ);
      end
      if (s_axis_rx_tlast) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      meta_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      drop_q  <= drop_d;
    end
  end

  ingress_out_slot #(.DATA_W(DATA_W), .KW(KW)) u_cpl_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (cpl_load_c),
    .in_data  (s_axis_rx_tdata),
    .in_keep  (s_axis_rx_tkeep),
    .in_sop   (first_c),
    .in_eop   (s_axis_rx_tlast),
    .in_meta  (meta_d),
    .free_c   (cpl_free_c),
    .out_data (cpl_data),
    .out_keep (cpl_keep),
    .out_sop  (cpl_sop),
    .out_eop  (cpl_eop),
    .out_meta (cpl_meta),
    .out_valid(cpl_valid),
    .out_rdy  (cpl_rdy)
  );

  ingress_out_slot #(.DATA_W(DATA_W), .KW(KW)) u_req_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (req_load_c),
    .in_data  (s_axis_rx_tdata),
    .in_keep  (s_axis_rx_tkeep),
    .in_sop   (first_c),
    .in_eop   (s_axis_rx_tlast),
    .in_meta  (meta_d),
    .free_c   (req_free_c),
    .out_data (req_data),
    .out_keep (req_keep),
    .out_sop  (req_sop),
    .out_eop  (req_eop),
    .out_meta (req_meta),
    .out_valid(req_valid),
    .out_rdy  (req_rdy)
  );

  assign s_axis_rx_tready = tready_c;
  assign drop_cnt         = drop_q;

endmodule
